// File: rtl/quadrant_pkg.sv
// Shared definitions for the quadrant sequencer and the quadrant mux:
// state encoding, default game parameters and internal counter widths.
package quadrant_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0000,
        ST_ADD      = 4'b0001,
        ST_SHOW_ON  = 4'b0011,
        ST_SHOW_OFF = 4'b0100,
        ST_WAIT_IN  = 4'b0101,
        ST_CHECK    = 4'b0110,
        ST_WIN      = 4'b0111,
        ST_LOSE     = 4'b1000
    } state_t;

    localparam int DEF_MAX_LEN    = 8;
    localparam int DEF_SHOW_TICKS = 2;
    localparam int DEF_GAP_TICKS  = 1;

    localparam int IDX_W  = 4;
    localparam int LEN_W  = 5;
    localparam int TCNT_W = 8;

    // True when the tick being counted now is the last one of a phase.
    function automatic logic tc_hit(input logic [TCNT_W-1:0] cnt, input int ticks);
        return cnt == TCNT_W'(ticks - 1);
    endfunction

endpackage

// File: rtl/seq_store.sv
// Sequence memory: DEPTH entries of 2-bit quadrant codes, one synchronous
// write port and one asynchronous read port. Contents are not reset.
module seq_store
    import quadrant_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_LEN
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [1:0]       wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [1:0]       rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0] mem [DEPTH];
    logic       wr_in_range;
    logic       rd_in_range;

    assign wr_in_range = {1'b0, wr_addr} < LEN_W'(DEPTH);
    assign rd_in_range = {1'b0, rd_addr} < LEN_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = rd_in_range ? mem[rd_addr[AW-1:0]] : 2'b00;

endmodule

// File: rtl/quadrant_sequencer.sv
// Memory-game sequencer: grows a random quadrant sequence, plays it back on
// tick pulses, then checks the player's button presses against it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start
// ADD      | append rand_quad to the sequence (one cycle)
// SHOW_ON  | quadrant seq[idx] lit for SHOW_TICKS ticks
// SHOW_OFF | dark gap of GAP_TICKS ticks between playback entries
// WAIT_IN  | waiting for a button press
// CHECK    | compare latched press with seq[idx] (one cycle)
// WIN      | full sequence of MAX_LEN repeated correctly
// LOSE     | wrong press
module quadrant_sequencer
    import quadrant_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int SHOW_TICKS = DEF_SHOW_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] rand_quad,
    input  logic       btn_valid,
    input  logic [1:0] btn_quad,
    output logic [3:0] state,
    output logic [1:0] cuadrante_fsm,
    output logic       highlight,
    output logic [4:0] seq_len,
    output logic       win,
    output logic       lose
);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    seq_len_q, seq_len_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [1:0]          btn_q, btn_d;
    logic [1:0]          quad_q;
    logic [1:0]          quad_out;
    logic                wr_en;
    logic [1:0]          rd_data;
    logic [LEN_W-1:0]    last_idx;
    logic                at_last;

    seq_store #(
        .DEPTH (MAX_LEN)
    ) u_seq_store (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (seq_len_q[IDX_W-1:0]),
        .wr_data (rand_quad),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign last_idx = seq_len_q - LEN_W'(1);
    assign at_last  = ({1'b0, idx_q} == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            seq_len_q <= '0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            btn_q     <= '0;
            quad_q    <= '0;
        end else begin
            state_q   <= state_d;
            seq_len_q <= seq_len_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            btn_q     <= btn_d;
            quad_q    <= quad_out;
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_len_d = seq_len_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        btn_d     = btn_q;
        wr_en     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    seq_len_d = '0;
                    idx_d     = '0;
                    state_d   = ST_ADD;
                end
            end
            ST_ADD: begin
                wr_en     = 1'b1;
                seq_len_d = seq_len_q + LEN_W'(1);
                idx_d     = '0;
                tcnt_d    = '0;
                state_d   = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (tick) begin
                    if (tc_hit(tcnt_q, SHOW_TICKS)) begin
                        tcnt_d  = '0;
                        state_d = ST_SHOW_OFF;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_SHOW_OFF: begin
                if (tick) begin
                    if (tc_hit(tcnt_q, GAP_TICKS)) begin
                        tcnt_d = '0;
                        if (at_last) begin
                            idx_d   = '0;
                            state_d = ST_WAIT_IN;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ST_SHOW_ON;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            ST_WAIT_IN: begin
                if (btn_valid) begin
                    btn_d   = btn_quad;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (btn_q != rd_data) begin
                    state_d = ST_LOSE;
                end else if (!at_last) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_WAIT_IN;
                end else if (seq_len_q == LEN_W'(MAX_LEN)) begin
                    state_d = ST_WIN;
                end else begin
                    state_d = ST_ADD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The displayed quadrant is held in quad_q outside SHOW_ON and CHECK.
    always_comb begin
        quad_out = quad_q;
        if (state_q == ST_SHOW_ON) begin
            quad_out = rd_data;
        end else if (state_q == ST_CHECK) begin
            quad_out = btn_q;
        end
    end

    assign state         = state_q;
    assign cuadrante_fsm = quad_out;
    assign highlight     = (state_q == ST_SHOW_ON) || (state_q == ST_CHECK);
    assign seq_len       = seq_len_q;
    assign win           = (state_q == ST_WIN);
    assign lose          = (state_q == ST_LOSE);

endmodule

// File: tb/tb_quadrant_sequencer.sv
// Scoreboard bench: each stimulus cycle pushes the expected post-edge outputs,
// which are popped and compared once the DUT has clocked that cycle.
module tb_quadrant_sequencer;

    localparam logic [3:0] S_IDLE = 4'b0000, S_ADD = 4'b0001, S_ON = 4'b0011,
                           S_OFF = 4'b0100, S_WAIT = 4'b0101, S_CHK = 4'b0110,
                           S_WIN = 4'b0111, S_LOSE = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] rand_quad = 2'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_quad = 2'd0;

    logic [3:0] state_a, state_b;
    logic [1:0] quad_a, quad_b;
    logic       hl_a, hl_b, win_a, win_b, lose_a, lose_b;
    logic [4:0] len_a, len_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         sel;
        string      tag;
        logic [3:0] st;
        logic [1:0] q;
        logic       hl;
        logic [4:0] len;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    quadrant_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tick(tick),
        .rand_quad(rand_quad), .btn_valid(btn_valid), .btn_quad(btn_quad),
        .state(state_a), .cuadrante_fsm(quad_a), .highlight(hl_a),
        .seq_len(len_a), .win(win_a), .lose(lose_a)
    );

    quadrant_sequencer #(.MAX_LEN(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tick(tick),
        .rand_quad(rand_quad), .btn_valid(btn_valid), .btn_quad(btn_quad),
        .state(state_b), .cuadrante_fsm(quad_b), .highlight(hl_b),
        .seq_len(len_b), .win(win_b), .lose(lose_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, clock it, compare.
    task automatic step(input string tag, input int sel, input logic s, input logic t,
                        input logic [1:0] rq, input logic bv, input logic [1:0] bq,
                        input logic [3:0] est, input logic [1:0] eq,
                        input logic ehl, input logic [4:0] elen);
        exp_t e;
        e.sel = sel; e.tag = tag; e.st = est; e.q = eq; e.hl = ehl; e.len = elen;
        sb.push_back(e);
        if (sel == 0) start_a = s; else start_b = s;
        tick = t; rand_quad = rq; btn_valid = bv; btn_quad = bq;
        @(posedge clk);
        #1;
        start_a = 1'b0; start_b = 1'b0; tick = 1'b0; btn_valid = 1'b0;
        e = sb.pop_front();
        if (e.sel == 0) begin
            chk({e.tag, ".st"},   int'(state_a), int'(e.st));
            chk({e.tag, ".q"},    int'(quad_a),  int'(e.q));
            chk({e.tag, ".hl"},   int'(hl_a),    int'(e.hl));
            chk({e.tag, ".len"},  int'(len_a),   int'(e.len));
            chk({e.tag, ".win"},  int'(win_a),   int'(e.st == S_WIN));
            chk({e.tag, ".lose"}, int'(lose_a),  int'(e.st == S_LOSE));
        end else begin
            chk({e.tag, ".st"},   int'(state_b), int'(e.st));
            chk({e.tag, ".q"},    int'(quad_b),  int'(e.q));
            chk({e.tag, ".hl"},   int'(hl_b),    int'(e.hl));
            chk({e.tag, ".len"},  int'(len_b),   int'(e.len));
            chk({e.tag, ".win"},  int'(win_b),   int'(e.st == S_WIN));
            chk({e.tag, ".lose"}, int'(lose_b),  int'(e.st == S_LOSE));
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".st"},   int'(state_a), int'(S_IDLE));
        chk({tag, ".q"},    int'(quad_a),  0);
        chk({tag, ".hl"},   int'(hl_a),    0);
        chk({tag, ".len"},  int'(len_a),   0);
        chk({tag, ".win"},  int'(win_a),   0);
        chk({tag, ".lose"}, int'(lose_a),  0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;

        // first round: sequence [2], stray presses/start during playback
        step("add1",  0, 1, 0, 0, 0, 0, S_ADD,  2'd0, 0, 5'd0);
        step("on1",   0, 0, 0, 2, 0, 0, S_ON,   2'd2, 1, 5'd1);
        step("on1t",  0, 0, 1, 0, 0, 0, S_ON,   2'd2, 1, 5'd1);
        step("on1b",  0, 0, 0, 0, 1, 3, S_ON,   2'd2, 1, 5'd1);
        step("off1",  0, 0, 1, 0, 0, 0, S_OFF,  2'd2, 0, 5'd1);
        step("off1b", 0, 0, 0, 0, 1, 3, S_OFF,  2'd2, 0, 5'd1);
        step("off1s", 0, 1, 0, 0, 0, 0, S_OFF,  2'd2, 0, 5'd1);
        step("wait1", 0, 0, 1, 0, 0, 0, S_WAIT, 2'd2, 0, 5'd1);
        step("wait1t",0, 0, 1, 0, 0, 0, S_WAIT, 2'd2, 0, 5'd1);
        step("chk1",  0, 0, 1, 0, 1, 2, S_CHK,  2'd2, 1, 5'd1);
        step("add2",  0, 0, 0, 0, 0, 0, S_ADD,  2'd2, 0, 5'd1);
        // second round: sequence [2,0]
        step("on2a",  0, 0, 0, 0, 0, 0, S_ON,   2'd2, 1, 5'd2);
        step("on2at", 0, 0, 1, 0, 0, 0, S_ON,   2'd2, 1, 5'd2);
        step("off2a", 0, 0, 1, 0, 0, 0, S_OFF,  2'd2, 0, 5'd2);
        step("on2b",  0, 0, 1, 0, 0, 0, S_ON,   2'd0, 1, 5'd2);
        step("on2bt", 0, 0, 1, 0, 0, 0, S_ON,   2'd0, 1, 5'd2);
        step("off2b", 0, 0, 1, 0, 0, 0, S_OFF,  2'd0, 0, 5'd2);
        step("wait2", 0, 0, 1, 0, 0, 0, S_WAIT, 2'd0, 0, 5'd2);
        step("chk2a", 0, 0, 0, 0, 1, 2, S_CHK,  2'd2, 1, 5'd2);
        step("wait2b",0, 0, 0, 0, 0, 0, S_WAIT, 2'd2, 0, 5'd2);
        step("chk2b", 0, 0, 0, 0, 1, 0, S_CHK,  2'd0, 1, 5'd2);
        step("add3",  0, 0, 0, 0, 0, 0, S_ADD,  2'd0, 0, 5'd2);
        step("on3",   0, 0, 0, 1, 0, 0, S_ON,   2'd2, 1, 5'd3);

        // asynchronous reset in the middle of SHOW_ON
        #1 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(posedge clk);
        #1 chk_reset("midrst_hold");
        rst_n = 1'b1;

        // lose scenario: sequence [1], press 3
        step("add_l", 0, 1, 0, 0, 0, 0, S_ADD,  2'd0, 0, 5'd0);
        step("on_l",  0, 0, 0, 1, 0, 0, S_ON,   2'd1, 1, 5'd1);
        step("on_lt", 0, 0, 1, 0, 0, 0, S_ON,   2'd1, 1, 5'd1);
        step("off_l", 0, 0, 1, 0, 0, 0, S_OFF,  2'd1, 0, 5'd1);
        step("wait_l",0, 0, 1, 0, 0, 0, S_WAIT, 2'd1, 0, 5'd1);
        step("chk_l", 0, 0, 0, 0, 1, 3, S_CHK,  2'd3, 1, 5'd1);
        step("lose",  0, 0, 0, 0, 0, 0, S_LOSE, 2'd3, 0, 5'd1);
        step("lose_b",0, 0, 0, 0, 1, 1, S_LOSE, 2'd3, 0, 5'd1);
        step("rest_l",0, 1, 0, 0, 0, 0, S_ADD,  2'd3, 0, 5'd0);
        step("on_r",  0, 0, 0, 0, 0, 0, S_ON,   2'd0, 1, 5'd1);

        // win scenario on the MAX_LEN=2 instance: sequence [1,3]
        step("b_add1", 1, 1, 0, 0, 0, 0, S_ADD,  2'd0, 0, 5'd0);
        step("b_on1",  1, 0, 0, 1, 0, 0, S_ON,   2'd1, 1, 5'd1);
        step("b_on1t", 1, 0, 1, 0, 0, 0, S_ON,   2'd1, 1, 5'd1);
        step("b_off1", 1, 0, 1, 0, 0, 0, S_OFF,  2'd1, 0, 5'd1);
        step("b_wt1",  1, 0, 1, 0, 0, 0, S_WAIT, 2'd1, 0, 5'd1);
        step("b_chk1", 1, 0, 0, 0, 1, 1, S_CHK,  2'd1, 1, 5'd1);
        step("b_add2", 1, 0, 0, 0, 0, 0, S_ADD,  2'd1, 0, 5'd1);
        step("b_on2a", 1, 0, 0, 3, 0, 0, S_ON,   2'd1, 1, 5'd2);
        step("b_on2t", 1, 0, 1, 0, 0, 0, S_ON,   2'd1, 1, 5'd2);
        step("b_off2", 1, 0, 1, 0, 0, 0, S_OFF,  2'd1, 0, 5'd2);
        step("b_on2b", 1, 0, 1, 0, 0, 0, S_ON,   2'd3, 1, 5'd2);
        step("b_on2u", 1, 0, 1, 0, 0, 0, S_ON,   2'd3, 1, 5'd2);
        step("b_off3", 1, 0, 1, 0, 0, 0, S_OFF,  2'd3, 0, 5'd2);
        step("b_wt2",  1, 0, 1, 0, 0, 0, S_WAIT, 2'd3, 0, 5'd2);
        step("b_chk2", 1, 0, 0, 0, 1, 1, S_CHK,  2'd1, 1, 5'd2);
        step("b_wt3",  1, 0, 0, 0, 0, 0, S_WAIT, 2'd1, 0, 5'd2);
        step("b_chk3", 1, 0, 0, 0, 1, 3, S_CHK,  2'd3, 1, 5'd2);
        step("b_win",  1, 0, 0, 0, 0, 0, S_WIN,  2'd3, 0, 5'd2);
        step("b_winb", 1, 0, 0, 0, 1, 0, S_WIN,  2'd3, 0, 5'd2);
        step("b_rest", 1, 1, 0, 0, 0, 0, S_ADD,  2'd3, 0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/quadrant_sequencer.md
QUADRANT_SEQUENCER -- requirements
Module: quadrant_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum sequence length (2..16).
REQ-002 Parameter SHOW_TICKS, default 2, tick pulses for which a quadrant is lit during playback.
REQ-003 Parameter GAP_TICKS, default 1, tick pulses of dark gap between playback entries.
REQ-004 clk  in  1  system clock, single clock domain.
REQ-005 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 start  in  1  single-cycle pulse; begins a new game.
REQ-007 tick  in  1  single-cycle timing pulse (frame-derived), paces playback.
REQ-008 rand_quad  in  2  free-running random quadrant, sampled only in ADD.
REQ-009 btn_valid  in  1  single-cycle pulse; player pressed a quadrant.
REQ-010 btn_quad  in  2  quadrant pressed, valid with btn_valid.
REQ-011 state  out  4  current state code; drives the quadrant mux select.
REQ-012 cuadrante_fsm  out  2  quadrant chosen by sequencer (mux FSM input).
REQ-013 highlight  out  1  quadrant lit.
REQ-014 seq_len  out  5  entries currently in sequence.
REQ-015 win  out  1  high while in WIN.
REQ-016 lose  out  1  high while in LOSE.

Function
REQ-017 State codes SHALL be: IDLE 0000, ADD 0001, SHOW_ON 0011, SHOW_OFF 0100, WAIT_IN 0101, CHECK 0110, WIN 0111, LOSE 1000; state output SHALL equal the registered state.
REQ-018 IDLE, WIN, LOSE: start SHALL clear seq_len and idx to 0 and enter ADD next cycle; start in any other state SHALL be ignored.
REQ-019 ADD: lasts one cycle; SHALL store rand_quad into seq[seq_len], increment seq_len, clear idx and tick counter, go to SHOW_ON.
REQ-020 SHOW_ON: cuadrante_fsm = seq[idx], highlight = 1; on the SHOW_TICKS-th tick SHALL go to SHOW_OFF with tick counter cleared.
REQ-021 SHOW_OFF: highlight = 0; on the GAP_TICKS-th tick SHALL go to WAIT_IN with idx=0 if idx == seq_len-1, else increment idx and go to SHOW_ON.
REQ-022 WAIT_IN: highlight = 0; btn_valid SHALL latch btn_quad and go to CHECK; tick SHALL be ignored.
REQ-023 CHECK: one cycle; cuadrante_fsm = latched button, highlight = 1.
REQ-024 CHECK on mismatch with seq[idx] SHALL go to LOSE.
REQ-025 CHECK on match SHALL increment idx and return to WAIT_IN when idx < seq_len-1; when idx == seq_len-1, go to WIN if seq_len == MAX_LEN, else ADD.
REQ-026 btn_valid outside WAIT_IN SHALL be dropped, never queued.
REQ-027 cuadrante_fsm SHALL hold its last value in states not listed above.
REQ-028 Counters SHALL count only tick pulses, never clock cycles; tick and btn_valid in the same cycle SHALL both be honoured per their state rules.

Reset
REQ-029 While rst_n low: state = IDLE, cuadrante_fsm = 00, highlight = 0, seq_len = 0, win = 0, lose = 0, idx and tick counter = 0; sequence contents need not be cleared.
REQ-030 Reset asserted mid-game SHALL abort immediately; first cycle after release SHALL be IDLE.

Structure
REQ-031 State enum (4-bit codes above) and default parameter values SHALL live in package quadrant_pkg, shared with the quadrant mux.
REQ-032 Sequence storage SHALL be sub-module seq_store (MAX_LEN x 2-bit registers, one write port, one async read port).

Verification
REQ-033 Reset mid SHOW_ON: drop rst_n -> state 0000, highlight 0, seq_len 0 within same cycle; start after release -> ADD.
REQ-034 start, rand_quad=2 -> ADD one cycle, seq_len 1, SHOW_ON with cuadrante_fsm 2 for exactly 2 ticks, SHOW_OFF 1 tick, WAIT_IN.
REQ-035 Sequence [2,0], press 2 then 0 -> CHECK twice, then ADD, seq_len 3.
REQ-036 Sequence [1], press 3 -> CHECK shows 3, then LOSE, lose=1; start -> seq_len 0, ADD.
REQ-037 MAX_LEN=2, correct inputs both rounds -> WIN, win=1 after second match.
REQ-038 btn_valid pulses during SHOW_ON/SHOW_OFF -> ignored; state sequence unchanged.
